// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one 16x2 LCD between two requesters; holds the granted lines for HOLD_CYCLES.
// Optional feature LCD_ARB_IDLE_MSG_EN: show IDLE_L1/IDLE_L2 after reset and whenever a hold expires.
module lcd_msg_arbiter #(
    parameter int unsigned  HOLD_CYCLES = 50000000,
    parameter int unsigned  CNT_W       = 26,
    parameter logic [127:0] IDLE_L1     = 128'("  LCD  IDLE    "),
    parameter logic [127:0] IDLE_L2     = 128'("                ")
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [127:0] msg0_l1,
    input  logic [127:0] msg0_l2,
    input  logic         req1,
    input  logic [127:0] msg1_l1,
    input  logic [127:0] msg1_l2,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic         busy,
    output logic         owner
);
    localparam logic [127:0]     SPACES   = {16{8'h20}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

`ifdef LCD_ARB_IDLE_MSG_EN
    localparam logic [127:0] RST_L1 = IDLE_L1;
    localparam logic [127:0] RST_L2 = IDLE_L2;
`else
    localparam logic [127:0] RST_L1 = SPACES;
    localparam logic [127:0] RST_L2 = SPACES;
    logic unused_idle;
    assign unused_idle = ^{IDLE_L1, IDLE_L2};
`endif

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [1:0]       gnt_q, gnt_d, done_q, done_d;
    logic [127:0]     line1_d, line2_d;
    logic             busy_d, owner_d;
    logic             any_req, win;

    assign any_req = req0 | req1;
    // On a tie the requester that did not win last time goes next.
    assign win     = (req0 && req1) ? ~last_q : req1;

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign done0 = done_q[0];
    assign done1 = done_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            done_q  <= '0;
            line1   <= RST_L1;
            line2   <= RST_L2;
            busy    <= 1'b0;
            owner   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            line1   <= line1_d;
            line2   <= line2_d;
            busy    <= busy_d;
            owner   <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = HOLD;
                cnt_d   = CNT_INIT;
            end
            HOLD: if (cnt_q == '0) state_d = IDLE;
                  else             cnt_d   = cnt_q - CNT_W'(1);
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; pulses default low every cycle.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        line1_d = line1;
        line2_d = line2;
        busy_d  = busy;
        owner_d = owner;
        last_d  = last_q;
        case (state_q)
            IDLE: if (any_req) begin
                gnt_d[win] = 1'b1;
                line1_d    = win ? msg1_l1 : msg0_l1;
                line2_d    = win ? msg1_l2 : msg0_l2;
                busy_d     = 1'b1;
                owner_d    = win;
                last_d     = win;
            end
            HOLD: if (cnt_q == '0) begin
                busy_d        = 1'b0;
                done_d[owner] = 1'b1;
`ifdef LCD_ARB_IDLE_MSG_EN
                line1_d       = IDLE_L1;
                line2_d       = IDLE_L2;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter: a cycle-indexed grant/done model feeds queues checked by a monitor.
module tb_lcd_msg_arbiter;
    localparam int HOLD = 4;
    localparam logic [127:0] SP = {16{8'h20}};

    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [127:0] msg0_l1 = '0, msg0_l2 = '0, msg1_l1 = '0, msg1_l2 = '0;
    logic gnt0, gnt1, done0, done1, busy, owner;
    logic [127:0] line1, line2;

    lcd_msg_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(26)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .msg0_l1(msg0_l1), .msg0_l2(msg0_l2),
        .req1(req1), .msg1_l1(msg1_l1), .msg1_l2(msg1_l2),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .line1(line1), .line2(line2), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct { int e; bit w; logic [127:0] l1; logic [127:0] l2; } ev_t;
    ev_t gq[$], dq[$];
    int  edge_cnt = 0, checks = 0, failures = 0;
    int  free_edge = 0;
    bit  last = 1'b1, gv = 1'b0, gw = 1'b0;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++; failures++;
        $display("FAIL %s edge=%0d got=none want=pulse", name, edge_cnt);
    endtask

    // Model: predict what happens at the next rising edge from the inputs now applied, then advance.
    task automatic cyc();
        int  n;
        ev_t g, d;
        n  = edge_cnt + 1;
        gv = 1'b0;
        if (reset) begin
            gq.delete(); dq.delete();
            last = 1'b1; free_edge = n + 1;
        end else if (n >= free_edge && (req0 || req1)) begin
            gw = (req0 && req1) ? !last : req1;
            gv = 1'b1;
            g.e = n; g.w = gw;
            g.l1 = gw ? msg1_l1 : msg0_l1;
            g.l2 = gw ? msg1_l2 : msg0_l2;
            gq.push_back(g);
            d = g; d.e = n + HOLD;
            dq.push_back(d);
            free_edge = n + HOLD + 1;
            last = gw;
        end
        @(negedge clk);
    endtask

    // Monitor: pop expectations when the DUT pulses, flag expectations that come due unseen.
    logic [127:0] m_l1 = SP, m_l2 = SP;
    bit m_busy = 1'b0, m_owner = 1'b0;
    initial forever begin
        ev_t e;
        @(posedge clk); #1;
        if (reset) begin
            chk("rst_pulses", {gnt1, gnt0, done1, done0}, 4'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_owner", owner, 1'b0);
            chk("rst_line1", line1, SP);
            chk("rst_line2", line2, SP);
            m_l1 = SP; m_l2 = SP; m_busy = 1'b0; m_owner = 1'b0;
        end else begin
            if (gnt0 && gnt1) chk("gnt_excl", {gnt1, gnt0}, 2'b01);
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) chk("gnt_unexp", {gnt1, gnt0}, 2'b00);
                else begin
                    e = gq.pop_front();
                    chk("gnt_edge", edge_cnt, e.e);
                    chk("gnt_who", gnt1, e.w);
                    m_l1 = e.l1; m_l2 = e.l2; m_busy = 1'b1; m_owner = e.w;
                end
            end else if (gq.size() != 0 && gq[0].e <= edge_cnt) begin
                miss("gnt_missing"); void'(gq.pop_front());
            end
            if (done0 && done1) chk("done_excl", {done1, done0}, 2'b01);
            if (done0 || done1) begin
                if (dq.size() == 0) chk("done_unexp", {done1, done0}, 2'b00);
                else begin
                    e = dq.pop_front();
                    chk("done_edge", edge_cnt, e.e);
                    chk("done_who", done1, e.w);
                    m_busy = 1'b0;
                end
            end else if (dq.size() != 0 && dq[0].e <= edge_cnt) begin
                miss("done_missing"); void'(dq.pop_front());
            end
            chk("line1", line1, m_l1);
            chk("line2", line2, m_l2);
            chk("busy", busy, m_busy);
            chk("owner", owner, m_owner);
        end
    end

    initial begin
        @(negedge clk);
        repeat (3) cyc();
        reset = 1'b0;

        // Single requester with a known message.
        msg0_l1 = "WELCOME TO CSE, ";
        msg0_l2 = "IIT KANPUR      ";
        req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        // Change msg0 and hold req1 during the hold window.
        msg0_l1 = {4{$urandom}}; msg0_l2 = {4{$urandom}};
        msg1_l1 = {4{$urandom}}; msg1_l2 = {4{$urandom}};
        req1 = 1'b1;
        for (int i = 0; i < 20 && !(gv && gw); i++) cyc();
        req1 = 1'b0;
        repeat (HOLD + 2) cyc();

        // Reset two cycles into a hold.
        req0 = 1'b1; cyc(); req0 = 1'b0;
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        req0 = 1'b1; cyc(); req0 = 1'b0;
        repeat (HOLD + 1) cyc();

        // Both held continuously: grants must alternate.
        req0 = 1'b1; req1 = 1'b1;
        repeat (4 * (HOLD + 1)) cyc();
        req0 = 1'b0; req1 = 1'b0;

        // Randomized traffic with occasional resets and dropped requests.
        for (int i = 0; i < 800; i++) begin
            if (req0 && gv && !gw)                req0 = 1'b0;
            else if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
            else if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
            if (req1 && gv && gw)                 req1 = 1'b0;
            else if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
            else if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
            if ($urandom_range(1) == 0) begin msg0_l1 = {4{$urandom}}; msg0_l2 = {4{$urandom}}; end
            if ($urandom_range(1) == 0) begin msg1_l1 = {4{$urandom}}; msg1_l2 = {4{$urandom}}; end
            reset = ($urandom_range(199) == 0);
            cyc();
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (HOLD + 3) cyc();
        checks++;
        if (gq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d pending want=0/0", gq.size(), dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
